// File: rtl/pc_branch_ctrl.sv
// Fetch PC owner: resolves branch/JAL/JALR in EX, redirects fetch, holds flush
// for FLUSH_CYCLES after each accepted redirect and counts redirects (saturating).
module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             br_en,
  input  logic             b,
  input  logic             jal,
  input  logic             jalr,
  input  logic [31:0]      pc_ex,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_d,
  output logic [31:0]      pc,
  output logic [31:0]      link_d,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0]       CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic             ONE_FC   = (FLUSH_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [31:0]      w_pc_nxt, w_target, w_pc_seq;
  logic             w_flush_nxt, w_mis_nxt, w_take, w_bad;
  logic [CNT_W-1:0] w_taken_nxt;

  assign link_d   = pc_ex + 32'd4;
  // jal wins over jalr; conditional branches share the pc-relative target
  assign w_target = (jalr & ~jal) ? ((rs1_d + imm) & ~32'h1) : (pc_ex + imm);
  assign w_take   = (r_state == RUN) & ex_valid & (jal | jalr | (br_en & b));
  assign w_bad    = |w_target[1:0];
  assign w_pc_seq = stall ? pc : pc + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = w_pc_seq;
    w_flush_nxt = flush;
    w_cnt_nxt   = r_cnt;
    w_mis_nxt   = 1'b0;
    w_taken_nxt = taken_cnt;
    case (r_state)
      RUN: begin
        w_flush_nxt = 1'b0;
        if (w_take && !w_bad) begin
          // redirect overrides stall
          w_pc_nxt    = w_target;
          w_flush_nxt = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = ONE_FC ? RUN : FLUSH;
          if (!(&taken_cnt)) w_taken_nxt = taken_cnt + CNT_ONE;
        end else if (w_take) begin
          w_mis_nxt = 1'b1;
        end
      end
      FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_flush_nxt = 1'b0;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_cnt     <= 3'd0;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      misalign  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      pc        <= w_pc_nxt;
      flush     <= w_flush_nxt;
      misalign  <= w_mis_nxt;
      taken_cnt <= w_taken_nxt;
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: stimulus pushes expected outputs from a
// behavioural model; a monitor pops and compares one entry per clock.
module tb_pc_branch_ctrl;
  localparam logic [31:0] RPC = 32'h100;
  localparam int          FC  = 2;
  localparam int          CW  = 2;

  logic clk = 0, rst_n = 1, stall = 0, ex_valid = 0, br_en = 0, b = 0, jal = 0, jalr = 0;
  logic [31:0] pc_ex = 0, imm = 0, rs1_d = 0;
  logic [31:0] pc, link_d;
  logic flush, misalign;
  logic [CW-1:0] taken_cnt;

  pc_branch_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .br_en(br_en),
    .b(b), .jal(jal), .jalr(jalr), .pc_ex(pc_ex), .imm(imm), .rs1_d(rs1_d),
    .pc(pc), .link_d(link_d), .flush(flush), .misalign(misalign), .taken_cnt(taken_cnt));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic flush; logic mis; int cnt;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // model: flush cycles still to show, redirect count, next fetch address
  logic [31:0] m_pc;
  int m_rem, m_cnt;
  logic m_mis;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, want);
    end
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_rem = 0; m_cnt = 0; m_mis = 0;
  endtask

  // called at a negedge; drives one cycle of inputs and returns at the next negedge
  task automatic cyc(input logic st, ev, be, bb, j, jr, input logic [31:0] pe, im, rs);
    logic [31:0] tgt;
    logic tk;
    stall = st; ex_valid = ev; br_en = be; b = bb; jal = j; jalr = jr;
    pc_ex = pe; imm = im; rs1_d = rs;
    #1 chk("link_d", link_d, pe + 32'd4);
    if (m_rem > 0 && FC > 1) begin
      m_rem--; m_mis = 0;
      if (!st) m_pc = m_pc + 4;
    end else begin
      tk  = ev && (j || jr || (be && bb));
      tgt = (jr && !j) ? ((rs + im) & ~32'h1) : (pe + im);
      if (tk && tgt[1:0] == 2'b00) begin
        m_pc = tgt; m_rem = FC; m_mis = 0;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else begin
        m_mis = tk; m_rem = 0;
        if (!st) m_pc = m_pc + 4;
      end
    end
    q.push_back('{pc: m_pc, flush: (m_rem > 0), mis: m_mis, cnt: m_cnt});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  // reset pulled low mid-cycle; outputs must clear without waiting for a clock
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_mis", 32'(misalign), 0);
    chk("rst_cnt", 32'(taken_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("flush", 32'(flush), 32'(e.flush));
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("taken_cnt", 32'(taken_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    logic st, ev, bb;
    logic [31:0] pe, im, rs;
    int kind;
    @(negedge clk);
    do_reset();
    idle(3);
    // conditional branch taken backwards, then not taken
    cyc(0, 1, 1, 1, 0, 0, 32'h20, -32'd16, 32'h0);
    idle(3);
    cyc(0, 1, 1, 0, 0, 0, 32'h20, -32'd16, 32'h0);
    idle(1);
    // jalr misaligned, then aligned after bit-0 clear
    cyc(0, 1, 0, 0, 0, 1, 32'h40, 32'h0, 32'h1003);
    idle(1);
    cyc(0, 1, 0, 0, 0, 1, 32'h40, 32'h0, 32'h1001);
    idle(3);
    // jal under stall, second jal offered during flush, stall held
    cyc(1, 1, 0, 0, 1, 0, 32'h80, 32'h40, 32'h0);
    cyc(1, 1, 0, 0, 1, 0, 32'h200, 32'h40, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    idle(1);
    // address wrap, then a run of redirects to saturate the counter
    cyc(0, 1, 1, 1, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 1, 0, 32'h300 + 32'(i * 16), 32'h100, 32'h0);
      idle(2);
    end
    for (int i = 0; i < 400; i++) begin
      st   = ($urandom_range(0, 3) == 0);
      ev   = $urandom_range(0, 1);
      bb   = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      pe   = $urandom & ~32'h3;
      im   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
      rs   = $urandom & ~32'h2;
      if ($urandom_range(0, 4) == 0) rs = $urandom;
      if (m_rem == 1) ev = 0;
      cyc(st, ev, kind == 1, bb, kind == 2, kind == 3, pe, im, rs);
      if (i == 200) begin
        do_reset();
      end
    end
    idle(2);
    // redirect, then reset while flush is high
    cyc(0, 1, 0, 0, 1, 0, 32'h500, 32'h40, 32'h0);
    chk("pre_rst_flush", 32'(flush), 1);
    do_reset();
    idle(2);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
